musa_boot_ctrl: RTL and testbench
=================================

// Module: musa_boot_ctrl
// PURPOSE
//  Boot/load sequencer for the MUSA core. Holds the processor in reset, then
//  fills instruction and data memory from a word stream (valid/ready). On a
//  GO header it releases the core. Sits between the host/loader interface and
//  the memories' write ports, and drives the core reset.
// PARAMETERS
//  DATA_WIDTH       32  stream/memory word width; must be >= 32
//  INST_ADDR_WIDTH  10  instruction memory word-address width; must be <= 14
//  DATA_ADDR_WIDTH  10  data memory word-address width; must be <= 14
// PORTS
//  clk       in   1                one clock for the whole block
//  rst       in   1                synchronous, active-high reset
//  s_valid   in   1                stream word valid
//  s_data    in   DATA_WIDTH       stream word (header or payload)
//  s_ready   out  1                block accepts s_data this cycle
//  reload    in   1                1-cycle pulse; RUN -> HEADER (core re-held)
//  im_we     out  1                instruction memory write strobe
//  im_addr   out  INST_ADDR_WIDTH  instruction memory word address
//  im_wdata  out  DATA_WIDTH       instruction memory write data
//  dm_we     out  1                data memory write strobe
//  dm_addr   out  DATA_ADDR_WIDTH  data memory word address
//  dm_wdata  out  DATA_WIDTH       data memory write data
//  core_rst  out  1                active-high reset to processor core
//  busy      out  1                1 while in LOAD
// BEHAVIOUR
//  - Transfer: a word is accepted when s_valid & s_ready at posedge clk.
//  - s_ready = 1 in HEADER and LOAD, 0 in RUN. It is decoded from state only,
//    with no dependence on s_valid.
//  - Header fields:
//      [31]    sel: 0 = instruction mem, 1 = data mem
//      [30]    go
//      [29:16] base word address, low bits used
//      [15:0]  word count
//  - States:
//    HEADER: waits for a header.
//      * go=1 -> RUN. The rest of the header is ignored.
//      * go=0, count=0 -> stay in HEADER (no-op).
//      * go=0, count>0 -> latch sel, addr=base, remaining=count; -> LOAD.
//    LOAD: each accepted word produces one write.
//      * The write strobe of the selected memory is 1 in the cycle after
//        acceptance, with the latched addr and the word.
//      * addr increments after each write. It wraps modulo 2^ADDR_WIDTH
//        with no error.
//      * remaining decrements on each write. Accepting the word with
//        remaining=1 -> HEADER.
//      * A header may be accepted in the very next cycle.
//    RUN: core_rst=0; stream stalled.
//      * reload=1 -> HEADER; core_rst=1 from the next cycle.
//      * reload is ignored in HEADER and LOAD.
//  - core_rst=1 in HEADER and LOAD. It falls 1 cycle after the go header is
//    accepted.
//  - Write strobes are 1 cycle wide, at most one per cycle. im_we and dm_we are
//    never 1 together.
//  - addr/wdata hold their last value when we=0.
//  - Reset values: state=HEADER, core_rst=1, im_we=dm_we=0, busy=0, addrs=0,
//    wdata=0. s_ready reads 1 in the first cycle after reset.
//  - rst mid-LOAD: the load is abandoned. No write strobe occurs in the cycle
//    after rst, even if a word was accepted in the rst cycle.
//  - The stream may idle (s_valid=0) indefinitely in LOAD. State and counters
//    hold.
// TESTING
//  1. Reset, then header 0x0000_0003 + words A,B,C:
//     -> im_we pulses at addr 0,1,2 with A,B,C; busy 1 during the load;
//        back to HEADER.
//  2. Header 0x8005_0002 + words D,E:
//     -> dm_we at addr 5 (D) and 6 (E); im_we stays 0.
//  3. Header 0x4000_0000:
//     -> core_rst 1->0 next cycle; s_ready=0.
//     Then reload pulse -> core_rst=1 and s_ready=1 next cycle.
//  4. Wrap: INST_ADDR_WIDTH=10, header 0x03FF_0002 + 2 words
//     -> writes at 0x3FF then 0x000.
//  5. Backpressure/idle: payload with s_valid gaps of 0-3 cycles
//     -> exactly one strobe per accepted word, in order.
//     Header 0x0000_0000 -> no writes, still HEADER.
//  6. rst asserted after 1 of 4 words
//     -> no further strobes, core_rst=1.
//     A new 1-word load then writes at base.

Source files
------------

// File: rtl/musa_boot_ctrl_if.sv
// Loader-side stream plus memory write ports and core control of the MUSA
// boot sequencer. master = host/loader side, slave = the sequencer.
interface musa_boot_ctrl_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int DATA_ADDR_WIDTH = 10
);
    logic                       s_valid;
    logic [DATA_WIDTH-1:0]      s_data;
    logic                       s_ready;
    logic                       reload;
    logic                       im_we;
    logic [INST_ADDR_WIDTH-1:0] im_addr;
    logic [DATA_WIDTH-1:0]      im_wdata;
    logic                       dm_we;
    logic [DATA_ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0]      dm_wdata;
    logic                       core_rst;
    logic                       busy;

    modport master (
        output s_valid, s_data, reload,
        input  s_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
               core_rst, busy
    );

    modport slave (
        input  s_valid, s_data, reload,
        output s_ready, im_we, im_addr, im_wdata, dm_we, dm_addr, dm_wdata,
               core_rst, busy
    );
endinterface

// File: rtl/musa_boot_ctrl.sv
// MUSA boot/load sequencer: holds the core in reset while headers and payload
// words stream in, writes payload into instruction or data memory, and
// releases the core on a GO header.
module musa_boot_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 10,
    parameter int DATA_ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    musa_boot_ctrl_if.slave  bus
);
    // One address counter serves both memories; each memory takes its low bits,
    // so wrap-around falls out of the truncation.
    localparam int AW = (INST_ADDR_WIDTH > DATA_ADDR_WIDTH) ? INST_ADDR_WIDTH : DATA_ADDR_WIDTH;

    localparam logic [1:0] ST_HEADER = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    logic [1:0]    state;
    logic          sel;        // 0 = instruction mem, 1 = data mem
    logic [AW-1:0] addr;
    logic [15:0]   remaining;
    logic          accept;

    // Handshake and status are pure state decodes.
    assign bus.s_ready  = (state != ST_RUN);
    assign bus.core_rst = (state != ST_RUN);
    assign bus.busy     = (state == ST_LOAD);
    assign accept       = bus.s_valid & bus.s_ready;

    // Sequencer: header decode, payload bookkeeping, run/reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HEADER;
            sel       <= 1'b0;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_HEADER: begin
                    if (accept) begin
                        if (bus.s_data[30]) begin
                            state <= ST_RUN;
                        end else if (bus.s_data[15:0] != 16'd0) begin
                            sel       <= bus.s_data[31];
                            addr      <= bus.s_data[16 +: AW];
                            remaining <= bus.s_data[15:0];
                            state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1)
                            state <= ST_HEADER;
                    end
                end
                ST_RUN: begin
                    if (bus.reload)
                        state <= ST_HEADER;
                end
                default: state <= ST_HEADER;
            endcase
        end
    end

    // Memory write ports: one registered strobe per accepted payload word;
    // address/data hold between writes. Reset wins over a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.im_we    <= 1'b0;
            bus.im_addr  <= '0;
            bus.im_wdata <= '0;
            bus.dm_we    <= 1'b0;
            bus.dm_addr  <= '0;
            bus.dm_wdata <= '0;
        end else begin
            bus.im_we <= 1'b0;
            bus.dm_we <= 1'b0;
            if (accept && state == ST_LOAD) begin
                if (sel) begin
                    bus.dm_we    <= 1'b1;
                    bus.dm_addr  <= addr[DATA_ADDR_WIDTH-1:0];
                    bus.dm_wdata <= bus.s_data;
                end else begin
                    bus.im_we    <= 1'b1;
                    bus.im_addr  <= addr[INST_ADDR_WIDTH-1:0];
                    bus.im_wdata <= bus.s_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_musa_boot_ctrl.sv
// Bench for musa_boot_ctrl: directed scenarios plus randomized loads, checked
// every cycle against a transaction-level model, with shadow memories for
// literal end-result checks.
module tb_musa_boot_ctrl;
    localparam int DW  = 32;
    localparam int IAW = 10;
    localparam int DAW = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    musa_boot_ctrl_if #(.DATA_WIDTH(DW), .INST_ADDR_WIDTH(IAW), .DATA_ADDR_WIDTH(DAW)) bus ();

    musa_boot_ctrl #(.DATA_WIDTH(DW), .INST_ADDR_WIDTH(IAW), .DATA_ADDR_WIDTH(DAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for header, 1 loading payload, 2 core running
    int              m_mode = 0;
    int              m_left = 0;
    int              m_ptr  = 0;
    bit              m_sel  = 0;
    logic            exp_im_we = 0, exp_dm_we = 0;
    logic [IAW-1:0]  exp_im_addr = '0;
    logic [DAW-1:0]  exp_dm_addr = '0;
    logic [DW-1:0]   exp_im_wdata = '0, exp_dm_wdata = '0;
    bit              chk_en = 0;

    always @(posedge clk) begin
        exp_im_we = 1'b0;
        exp_dm_we = 1'b0;
        if (rst) begin
            m_mode = 0; m_left = 0; m_ptr = 0;
            exp_im_addr = '0; exp_im_wdata = '0;
            exp_dm_addr = '0; exp_dm_wdata = '0;
        end else if (m_mode == 2) begin
            if (bus.reload) m_mode = 0;
        end else if (bus.s_valid) begin
            if (m_mode == 0) begin
                if (bus.s_data[30]) m_mode = 2;
                else if (bus.s_data[15:0] != 0) begin
                    m_sel  = bus.s_data[31];
                    m_ptr  = int'(bus.s_data[29:16]);
                    m_left = int'(bus.s_data[15:0]);
                    m_mode = 1;
                end
            end else begin
                if (m_sel) begin
                    exp_dm_we    = 1'b1;
                    exp_dm_addr  = DAW'(m_ptr % (1 << DAW));
                    exp_dm_wdata = bus.s_data;
                end else begin
                    exp_im_we    = 1'b1;
                    exp_im_addr  = IAW'(m_ptr % (1 << IAW));
                    exp_im_wdata = bus.s_data;
                end
                m_ptr++;
                m_left--;
                if (m_left == 0) m_mode = 0;
            end
        end
    end

    // ---------------- compare process + shadow memories ----------------
    logic [DW-1:0] sh_im [1 << IAW];
    logic [DW-1:0] sh_dm [1 << DAW];
    int im_cnt = 0, dm_cnt = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("im_we",    64'(bus.im_we),    64'(exp_im_we));
            cmp("dm_we",    64'(bus.dm_we),    64'(exp_dm_we));
            cmp("im_addr",  64'(bus.im_addr),  64'(exp_im_addr));
            cmp("im_wdata", 64'(bus.im_wdata), 64'(exp_im_wdata));
            cmp("dm_addr",  64'(bus.dm_addr),  64'(exp_dm_addr));
            cmp("dm_wdata", 64'(bus.dm_wdata), 64'(exp_dm_wdata));
            cmp("s_ready",  64'(bus.s_ready),  64'(m_mode != 2));
            cmp("core_rst", 64'(bus.core_rst), 64'(m_mode != 2));
            cmp("busy",     64'(bus.busy),     64'(m_mode == 1));
            cmp("we_excl",  64'(bus.im_we & bus.dm_we), 64'd0);
            if (bus.im_we === 1'b1) begin sh_im[bus.im_addr] = bus.im_wdata; im_cnt++; end
            if (bus.dm_we === 1'b1) begin sh_dm[bus.dm_addr] = bus.dm_wdata; dm_cnt++; end
        end
    end

    // ---------------- stimulus helpers (drive at posedge+2) ----------------
    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic send(input logic [31:0] w);
        bit ok;
        int n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        do begin
            ok = bus.s_ready;
            @(posedge clk); #2;
            n++;
        end while (!ok && n < 20);
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted within 20 cycles", w);
        end
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
    endtask

    task automatic send_gap(input logic [31:0] w, input int maxgap);
        idle($urandom_range(maxgap, 0));
        send(w);
    endtask

    logic [31:0] wv [8];
    int c0, d0, cnt;
    logic [31:0] hdr;

    initial begin
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.reload  = 1'b0;
        @(posedge clk); #1 chk_en = 1'b1;
        @(posedge clk); #2 rst = 1'b0;

        // reset state
        cmp("rst_ready", 64'(bus.s_ready), 64'd1);
        cmp("rst_core_rst", 64'(bus.core_rst), 64'd1);
        cmp("rst_busy", 64'(bus.busy), 64'd0);
        cmp("rst_im_addr", 64'(bus.im_addr), 64'd0);

        // 1: instruction load of three words at 0
        for (int i = 0; i < 3; i++) wv[i] = $urandom;
        send(32'h0000_0003);
        cmp("t1_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 3; i++) send(wv[i]);
        idle(2);
        for (int i = 0; i < 3; i++) cmp("t1_imem", 64'(sh_im[i]), 64'(wv[i]));
        cmp("t1_busy_end", 64'(bus.busy), 64'd0);

        // 2: data load at 5
        c0 = im_cnt; d0 = dm_cnt;
        wv[0] = $urandom; wv[1] = $urandom;
        send(32'h8005_0002);
        send(wv[0]); send(wv[1]);
        idle(2);
        cmp("t2_dmem5", 64'(sh_dm[5]), 64'(wv[0]));
        cmp("t2_dmem6", 64'(sh_dm[6]), 64'(wv[1]));
        cmp("t2_im_quiet", 64'(im_cnt), 64'(c0));
        cmp("t2_dm_cnt", 64'(dm_cnt), 64'(d0 + 2));

        // 3: go, stall while running, reload
        send(32'h4000_0000);
        cmp("t3_core_run", 64'(bus.core_rst), 64'd0);
        cmp("t3_ready_run", 64'(bus.s_ready), 64'd0);
        bus.s_valid = 1'b1; bus.s_data = 32'h0000_0001;
        idle(2);
        bus.s_valid = 1'b0;
        bus.reload = 1'b1; idle(1); bus.reload = 1'b0;
        cmp("t3_core_reheld", 64'(bus.core_rst), 64'd1);
        cmp("t3_ready_back", 64'(bus.s_ready), 64'd1);

        // 4: address wrap
        wv[0] = $urandom; wv[1] = $urandom;
        send(32'h03FF_0002);
        send(wv[0]); send(wv[1]);
        idle(2);
        cmp("t4_wrap_3ff", 64'(sh_im[10'h3FF]), 64'(wv[0]));
        cmp("t4_wrap_000", 64'(sh_im[0]), 64'(wv[1]));

        // 5: gapped payload, reload pulses ignored, then no-op header
        c0 = im_cnt;
        for (int i = 0; i < 6; i++) wv[i] = $urandom;
        send(32'h0020_0006);
        for (int i = 0; i < 6; i++) begin
            bus.reload = 1'(i == 2);
            send_gap(wv[i], 3);
            bus.reload = 1'b0;
        end
        idle(2);
        cmp("t5_cnt", 64'(im_cnt), 64'(c0 + 6));
        for (int i = 0; i < 6; i++) cmp("t5_imem", 64'(sh_im[32 + i]), 64'(wv[i]));
        send(32'h0000_0000);
        idle(2);
        cmp("t5_noop_cnt", 64'(im_cnt), 64'(c0 + 6));
        cmp("t5_noop_busy", 64'(bus.busy), 64'd0);

        // 6: reset during a load
        c0 = im_cnt;
        send(32'h0010_0004);
        send($urandom);
        bus.s_valid = 1'b1; bus.s_data = $urandom; rst = 1'b1;
        idle(1);
        rst = 1'b0; bus.s_valid = 1'b0;
        idle(3);
        cmp("t6_cnt", 64'(im_cnt), 64'(c0 + 1));
        cmp("t6_core_rst", 64'(bus.core_rst), 64'd1);
        wv[0] = $urandom;
        send(32'h0010_0001);
        send(wv[0]);
        idle(2);
        cmp("t6_reload_word", 64'(sh_im[16]), 64'(wv[0]));

        // randomized traffic
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(9, 0))
                0: send_gap(32'h0000_0000 | ($urandom & 32'hBFFF_0000), 2);
                1: begin
                    send_gap($urandom | 32'h4000_0000, 2);
                    bus.s_valid = 1'(($urandom & 1) != 0);
                    idle($urandom_range(3, 0));
                    bus.s_valid = 1'b0;
                    bus.reload = 1'b1; idle(1); bus.reload = 1'b0;
                end
                default: begin
                    cnt = $urandom_range(5, 1);
                    hdr = {1'(($urandom & 1) != 0), 1'b0, 14'($urandom), 16'(cnt)};
                    send_gap(hdr, 2);
                    for (int k = 0; k < cnt; k++) begin
                        bus.reload = 1'(($urandom_range(3, 0)) == 0);
                        send_gap($urandom, 3);
                        bus.reload = 1'b0;
                    end
                end
            endcase
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
